// File: rtl/fwd_hazard_ctrl_pkg.sv
// rtl/fwd_hazard_ctrl_pkg.sv - shared types and helpers for the forwarding/hazard controller
package fwd_hazard_ctrl_pkg;

    localparam int FWD_REG_W = 5;

    typedef logic [FWD_REG_W-1:0] reg_t;

    typedef struct packed {
        logic valid;
        logic wen;
        reg_t wnum;
        logic isLoad;
    } fwd_tag_t;

    localparam int TAG_W = $bits(fwd_tag_t);

    localparam fwd_tag_t BUBBLE_TAG = '{valid: 1'b0, wen: 1'b0, wnum: '0, isLoad: 1'b0};

    function automatic int fwd_sel_w(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

    // x0 is hardwired zero, so it never counts as a produced register
    function automatic logic tag_produces(input fwd_tag_t t, input reg_t r);
        return t.valid && t.wen && (t.wnum == r) && (r != '0);
    endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_tag_pipe.sv
// rtl/fwd_hazard_ctrl_tag_pipe.sv - shadow pipeline of destination tags, EX at entry 0
module fwd_tag_pipe
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int DEPTH = 3
)(
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_hold,
    input  logic                   i_insert,
    input  logic [TAG_W-1:0]       i_tag,
    output logic [DEPTH*TAG_W-1:0] o_tags
);

    fwd_tag_t [DEPTH-1:0] r_tags;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_tags[k] <= BUBBLE_TAG;
            end
        end else if (!i_hold) begin
            r_tags[0] <= i_insert ? fwd_tag_t'(i_tag) : BUBBLE_TAG;
            for (int k = 1; k < DEPTH; k++) begin
                r_tags[k] <= r_tags[k-1];
            end
        end
    end

    assign o_tags = r_tags;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - ID-stage forwarding select precompute and load-use stall
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int NUM_RPORTS     = 2,
    parameter int DEPTH          = 3,
    parameter int LOAD_FWD_STAGE = 2,
    parameter int REG_W          = 5,
    parameter int CNT_W          = 32
)(
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic                                i_hold,
    input  logic                                i_flush,
    input  logic                                i_ID_valid,
    input  logic [NUM_RPORTS-1:0]               i_ID_ren,
    input  logic [NUM_RPORTS*REG_W-1:0]         i_ID_rnum,
    input  logic                                i_ID_wen,
    input  logic [REG_W-1:0]                    i_ID_wnum,
    input  logic                                i_ID_isLoad,
    output logic [NUM_RPORTS*$clog2(DEPTH)-1:0] o_fwd_sel,
    output logic                                o_stall,
    output logic [CNT_W-1:0]                    o_stall_cnt
);

    localparam int SEL_W = fwd_sel_w(DEPTH);

    generate
        if (DEPTH < 2) begin : g_bad_depth
            $error("fwd_hazard_ctrl: DEPTH must be at least 2");
        end
        if (LOAD_FWD_STAGE < 1 || LOAD_FWD_STAGE > DEPTH - 1) begin : g_bad_lfs
            $error("fwd_hazard_ctrl: LOAD_FWD_STAGE must lie in 1..DEPTH-1");
        end
        if (REG_W != FWD_REG_W) begin : g_bad_regw
            $error("fwd_hazard_ctrl: REG_W must match package reg_t width");
        end
    endgenerate

    logic [DEPTH*TAG_W-1:0]      w_tags_flat;
    fwd_tag_t [DEPTH-1:0]        w_tags;
    fwd_tag_t                    w_id_tag;
    logic                        w_hazard;
    logic                        w_stall;
    logic                        w_insert;
    logic [NUM_RPORTS*SEL_W-1:0] w_sel_next;
    logic [NUM_RPORTS*SEL_W-1:0] r_fwd_sel;
    logic [CNT_W-1:0]            r_stall_cnt;

    assign w_id_tag = '{valid: 1'b1, wen: i_ID_wen, wnum: reg_t'(i_ID_wnum), isLoad: i_ID_isLoad};
    assign w_tags   = w_tags_flat;

    fwd_tag_pipe #(
        .DEPTH (DEPTH)
    ) u_tag_pipe (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_hold   (i_hold),
        .i_insert (w_insert),
        .i_tag    (w_id_tag),
        .o_tags   (w_tags_flat)
    );

    // Scan oldest to youngest so the youngest eligible producer overwrites the select.
    // A load too young to forward raises the hazard instead of being a source.
    always_comb begin
        w_hazard   = 1'b0;
        w_sel_next = '0;
        for (int p = 0; p < NUM_RPORTS; p++) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (i_ID_ren[p] && tag_produces(w_tags[k], reg_t'(i_ID_rnum[p*REG_W +: REG_W]))) begin
                    if (w_tags[k].isLoad && (k + 1 < LOAD_FWD_STAGE)) begin
                        w_hazard = 1'b1;
                    end else if (k < DEPTH - 1) begin
                        w_sel_next[p*SEL_W +: SEL_W] = SEL_W'(k + 1);
                    end
                end
            end
        end
    end

    assign w_stall  = i_ID_valid && !i_flush && w_hazard;
    assign w_insert = i_ID_valid && !w_stall && !i_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fwd_sel   <= '0;
            r_stall_cnt <= '0;
        end else if (!i_hold) begin
            r_fwd_sel <= w_insert ? w_sel_next : '0;
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign o_fwd_sel   = r_fwd_sel;
    assign o_stall     = w_stall;
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
Parametrised forwarding and load-use hazard controller for the integer pipeline. It keeps its own shadow pipeline of destination-register tags (EX..last stage) and computes the EX-stage operand forwarding selects one cycle early, in ID, so the selects arrive registered at EX. It also detects load-use hazards and stalls ID/IF with an inserted bubble. Generalises the fixed two-operand MEM/WB forwarder to N read ports, arbitrary pipeline depth and configurable load-data availability.

Parameters:
NUM_RPORTS, 2, number of EX operand read ports needing a forwarding select.
DEPTH, 3, tag pipeline entries; entry 0 = EX, 1 = MEM, 2 = WB, ...
LOAD_FWD_STAGE, 2, first stage index from which a load result may be forwarded.
REG_W, 5, register index width (reg_t).
CNT_W, 32, stall counter width.

Ports:
i_clk  in  1  clock, rising edge.
i_rst_n  in  1  asynchronous active-low reset.
i_hold  in  1  global pipeline freeze (e.g. memory busy); all state held.
i_flush  in  1  control-flow flush; ID instruction is not entered into EX.
i_ID_valid  in  1  ID holds a real instruction.
i_ID_ren  in  NUM_RPORTS  per-port read enable of ID instruction.
i_ID_rnum  in  NUM_RPORTS x REG_W  per-port source register of ID instruction.
i_ID_wen  in  1  ID instruction writes a register.
i_ID_wnum  in  REG_W  ID destination register.
i_ID_isLoad  in  1  ID instruction is a load.
o_fwd_sel  out  NUM_RPORTS x clog2(DEPTH)  per-port EX select: 0 = register file, k = forward from stage k (1..DEPTH-1).
o_stall  out  1  load-use stall to IF/ID (combinational).
o_stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset (async, i_rst_n=0): all tag entries invalid, o_fwd_sel all 0, o_stall_cnt 0; o_stall therefore 0.
- Tag entry = {valid, wen, wnum, isLoad}. Entry is "producing r" iff valid & wen & wnum==r & r!=0.
- Advance (i_hold=0, each edge): entry[k] <= entry[k-1] for k>=1; entry[0] <= ID tag if i_ID_valid & !o_stall & !i_flush, else bubble (valid=0).
- i_hold=1: all entries, o_fwd_sel and o_stall_cnt hold; o_stall still evaluated; i_flush ignored (source keeps flush asserted until hold drops).
- Forward select (registered, updated only on advance): for port p with ren=1 and rnum!=0, find smallest k in 0..DEPTH-2 with entry[k] producing rnum and not (isLoad & k+1 < LOAD_FWD_STAGE); o_fwd_sel[p] <= k+1. None found, ren=0, or rnum=0 -> 0. Youngest producer wins.
- On a bubble insert (stall/flush/invalid ID) o_fwd_sel <= 0.
- Entry DEPTH-1 is never a forward source for ID: register file is write-before-read in the same cycle.
- o_stall = i_ID_valid & !i_flush & exists p,k: ren[p], entry[k] producing rnum[p], entry[k].isLoad, k+1 < LOAD_FWD_STAGE. With defaults: exactly one stall cycle per load-use pair.
- Stall and flush same cycle: flush wins, o_stall=0, bubble inserted.
- o_stall_cnt increments on each edge with o_stall=1 & i_hold=0; saturates at all-ones.
- Elaboration check: DEPTH>=2, 1<=LOAD_FWD_STAGE<=DEPTH-1.

Decomposition:
- Shared package: reg_t (REG_W), fwd_tag_t struct {valid,wen,wnum,isLoad}, fwd_sel_t width function, BUBBLE_TAG constant.
- Sub-module fwd_tag_pipe: DEPTH-entry tag shift register with hold and bubble insert; top holds compare/select, stall logic and counter.

Test Plan:
- ID ADD x5 issued, next ID reads x5 on port0 -> after one advance o_fwd_sel[0]=1; one cycle later with an unrelated instruction between -> sel=2.
- Producers of x5 at entries 0 and 1 both, ID reads x5 on both ports -> both o_fwd_sel=1 (youngest), no stall.
- LW x7 in EX, ID reads x7 -> o_stall=1 one cycle, bubble into EX, then o_fwd_sel=2, o_stall_cnt=1.
- Producer writes x0, or ren=0 for matching rnum -> o_fwd_sel=0, o_stall=0.
- i_hold=1 for 3 cycles during a load-use hazard -> entries/o_fwd_sel/o_stall_cnt frozen, o_stall stays 1; release -> single counted stall; flush asserted with hazard -> o_stall=0, bubble.
- i_rst_n pulsed low mid-sequence with valid producers -> immediately all outputs 0; next ID reading former producer's register -> sel=0.
